// File: rtl/beta_trap_pkg.sv
// Shared constants and cause codes for the beta machine-mode trap controller.
package beta_trap_pkg;

  localparam int LOCAL_IRQ_BASE = 16;
  localparam int CAUSE_W        = 5;

  // trap_type_o encoding
  localparam logic [1:0] TRAP_NONE = 2'b00;
  localparam logic [1:0] TRAP_IRQ  = 2'b01;
  localparam logic [1:0] TRAP_EXC  = 2'b10;

  // instr_trap_i encoding
  localparam logic [1:0] ITRAP_NONE     = 2'b00;
  localparam logic [1:0] ITRAP_MISALIGN = 2'b01;
  localparam logic [1:0] ITRAP_ILLEGAL  = 2'b10;

  // lsu_trap_i encoding
  localparam logic [1:0] LTRAP_NONE  = 2'b00;
  localparam logic [1:0] LTRAP_LOAD  = 2'b01;
  localparam logic [1:0] LTRAP_STORE = 2'b10;

  typedef enum logic [CAUSE_W-1:0] {
    EXC_FETCH_MISALIGN = 5'd0,
    EXC_ILLEGAL        = 5'd2,
    EXC_LOAD_MISALIGN  = 5'd4,
    EXC_STORE_MISALIGN = 5'd6,
    EXC_ECALL_M        = 5'd11
  } exc_cause_e;

  typedef enum logic [CAUSE_W-1:0] {
    IRQ_MSI = 5'd3,
    IRQ_MTI = 5'd7,
    IRQ_MEI = 5'd11
  } irq_cause_e;

  typedef enum logic {ST_IDLE, ST_TRAP} trap_state_e;

  function automatic logic [CAUSE_W-1:0] local_cause(input int idx);
    return CAUSE_W'(LOCAL_IRQ_BASE + idx);
  endfunction

endpackage

// File: rtl/beta_trap_ctrl_if.sv
// Trap-source / CSR-capture bundle between the execute stage and the trap controller.
interface beta_trap_ctrl_if #(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int XLEN          = 32
);
  localparam int NIRQ = 16 + NUM_LOCAL_IRQ;

  logic                     instr_valid_i;
  logic [XLEN-1:0]          pc_i;
  logic [1:0]               instr_trap_i;
  logic [1:0]               lsu_trap_i;
  logic                     ecall_i;
  logic [31:0]              instr_word_i;
  logic [XLEN-1:0]          badaddr_i;
  logic                     mret_i;
  logic                     mstatus_mie_i;
  logic [NIRQ-1:0]          mie_i;
  logic [XLEN-1:0]          mtvec_i;
  logic                     irq_msw_i;
  logic                     irq_mtim_i;
  logic                     irq_mext_i;
  logic [NUM_LOCAL_IRQ-1:0] irq_local_i;
  logic                     flush_ack_i;

  logic                     trap_req_o;
  logic [1:0]               trap_type_o;
  logic [XLEN-1:0]          trap_pc_o;
  logic [XLEN-1:0]          mcause_o;
  logic [XLEN-1:0]          mepc_o;
  logic [XLEN-1:0]          mtval_o;
  logic                     csr_we_o;
  logic                     mret_o;
  logic [NIRQ-1:0]          mip_o;

  modport slave (
    input  instr_valid_i, pc_i, instr_trap_i, lsu_trap_i, ecall_i, instr_word_i,
           badaddr_i, mret_i, mstatus_mie_i, mie_i, mtvec_i, irq_msw_i, irq_mtim_i,
           irq_mext_i, irq_local_i, flush_ack_i,
    output trap_req_o, trap_type_o, trap_pc_o, mcause_o, mepc_o, mtval_o,
           csr_we_o, mret_o, mip_o
  );

  modport master (
    output instr_valid_i, pc_i, instr_trap_i, lsu_trap_i, ecall_i, instr_word_i,
           badaddr_i, mret_i, mstatus_mie_i, mie_i, mtvec_i, irq_msw_i, irq_mtim_i,
           irq_mext_i, irq_local_i, flush_ack_i,
    input  trap_req_o, trap_type_o, trap_pc_o, mcause_o, mepc_o, mtval_o,
           csr_we_o, mret_o, mip_o
  );

endinterface

// File: rtl/beta_irq_prio.sv
// Interrupt priority encoder: MEI > MSI > MTI > local lines, highest local index first.
module beta_irq_prio
  import beta_trap_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4
) (
  input  logic [LOCAL_IRQ_BASE+NUM_LOCAL_IRQ-1:0] pend_i,
  output logic                                    valid_o,
  output logic [CAUSE_W-1:0]                      cause_o
);

  // Reserved positions never carry a pending bit.
  logic unused_pend;
  assign unused_pend = ^{pend_i[15:12], pend_i[10:8], pend_i[6:4], pend_i[2:0]};

  // Later assignments override earlier ones, so the list runs lowest priority first.
  always_comb begin
    valid_o = 1'b0;
    cause_o = '0;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      if (pend_i[LOCAL_IRQ_BASE+i]) begin
        valid_o = 1'b1;
        cause_o = local_cause(i);
      end
    end
    if (pend_i[int'(IRQ_MTI)]) begin
      valid_o = 1'b1;
      cause_o = IRQ_MTI;
    end
    if (pend_i[int'(IRQ_MSI)]) begin
      valid_o = 1'b1;
      cause_o = IRQ_MSI;
    end
    if (pend_i[int'(IRQ_MEI)]) begin
      valid_o = 1'b1;
      cause_o = IRQ_MEI;
    end
  end

endmodule

// File: rtl/beta_trap_ctrl.sv
// Machine-mode trap controller: exception/interrupt arbitration, CSR capture, redirect hold.
// BETA_TRAP_VECTORED_EN enables vectored interrupt targets when mtvec mode is 01.
module beta_trap_ctrl
  import beta_trap_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int XLEN          = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  beta_trap_ctrl_if.slave bus
);

  localparam int NIRQ = LOCAL_IRQ_BASE + NUM_LOCAL_IRQ;

  trap_state_e              state;
  logic [NUM_LOCAL_IRQ-1:0] irq_prev, lpend, lpend_clr, lpend_nxt, local_edge;
  logic [NIRQ-1:0]          mip;
  logic                     irq_valid;
  logic [CAUSE_W-1:0]       irq_cause;
  logic                     exc_valid;
  logic [CAUSE_W-1:0]       exc_cause;
  logic [XLEN-1:0]          exc_tval;
  logic                     take_exc, take_irq, take;
  logic [XLEN-1:0]          cause_nxt, trap_base, trap_tgt;

  always_comb begin
    mip                      = '0;
    mip[int'(IRQ_MSI)]       = bus.irq_msw_i;
    mip[int'(IRQ_MTI)]       = bus.irq_mtim_i;
    mip[int'(IRQ_MEI)]       = bus.irq_mext_i;
    mip[NIRQ-1:LOCAL_IRQ_BASE] = lpend;
  end

  beta_irq_prio #(.NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)) u_prio (
    .pend_i  (mip & bus.mie_i),
    .valid_o (irq_valid),
    .cause_o (irq_cause)
  );

  always_comb begin
    exc_valid = 1'b1;
    exc_cause = EXC_FETCH_MISALIGN;
    exc_tval  = '0;
    if (bus.instr_trap_i == ITRAP_MISALIGN) begin
      exc_tval  = bus.badaddr_i;
    end else if (bus.instr_trap_i == ITRAP_ILLEGAL) begin
      exc_cause = EXC_ILLEGAL;
      exc_tval  = XLEN'(bus.instr_word_i);
    end else if (bus.ecall_i) begin
      exc_cause = EXC_ECALL_M;
    end else if (bus.lsu_trap_i == LTRAP_LOAD) begin
      exc_cause = EXC_LOAD_MISALIGN;
      exc_tval  = bus.badaddr_i;
    end else if (bus.lsu_trap_i == LTRAP_STORE) begin
      exc_cause = EXC_STORE_MISALIGN;
      exc_tval  = bus.badaddr_i;
    end else begin
      exc_valid = 1'b0;
    end
  end

  assign take_exc = (state == ST_IDLE) && bus.instr_valid_i && exc_valid;
  assign take_irq = (state == ST_IDLE) && bus.instr_valid_i && !exc_valid &&
                    bus.mstatus_mie_i && irq_valid;
  assign take     = take_exc || take_irq;

  always_comb begin
    cause_nxt                = '0;
    cause_nxt[XLEN-1]        = take_irq;
    cause_nxt[CAUSE_W-1:0]   = take_exc ? exc_cause : irq_cause;
  end

  assign trap_base = {bus.mtvec_i[XLEN-1:2], 2'b00};
`ifdef BETA_TRAP_VECTORED_EN
  assign trap_tgt = (take_irq && bus.mtvec_i[1:0] == 2'b01) ?
                    trap_base + (XLEN'(irq_cause) << 2) : trap_base;
`else
  logic unused_mode;
  assign unused_mode = ^bus.mtvec_i[1:0];
  assign trap_tgt    = trap_base;
`endif

  // A fresh edge on a line wins over the clear caused by taking that line.
  always_comb begin
    for (int i = 0; i < NUM_LOCAL_IRQ; i++)
      lpend_clr[i] = take_irq && (irq_cause == local_cause(i));
    local_edge = bus.irq_local_i & ~irq_prev;
    lpend_nxt  = (lpend & ~lpend_clr) | local_edge;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      irq_prev        <= '0;
      lpend           <= '0;
      bus.trap_req_o  <= 1'b0;
      bus.trap_type_o <= TRAP_NONE;
      bus.trap_pc_o   <= '0;
      bus.mcause_o    <= '0;
      bus.mepc_o      <= '0;
      bus.mtval_o     <= '0;
      bus.csr_we_o    <= 1'b0;
      bus.mret_o      <= 1'b0;
      bus.mip_o       <= '0;
    end else begin
      irq_prev     <= bus.irq_local_i;
      lpend        <= lpend_nxt;
      bus.mip_o    <= {lpend_nxt, mip[LOCAL_IRQ_BASE-1:0]};
      bus.csr_we_o <= take;
      bus.mret_o   <= (state == ST_IDLE) && bus.mret_i && !take;
      case (state)
        ST_IDLE: begin
          if (take) begin
            state           <= ST_TRAP;
            bus.trap_req_o  <= 1'b1;
            bus.trap_type_o <= take_exc ? TRAP_EXC : TRAP_IRQ;
            bus.trap_pc_o   <= trap_tgt;
            bus.mcause_o    <= cause_nxt;
            bus.mepc_o      <= bus.pc_i;
            bus.mtval_o     <= take_exc ? exc_tval : '0;
          end
        end
        ST_TRAP: begin
          if (bus.flush_ack_i) begin
            state           <= ST_IDLE;
            bus.trap_req_o  <= 1'b0;
            bus.trap_type_o <= TRAP_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_trap_ctrl.sv
// Scoreboard bench for beta_trap_ctrl: expected takes are queued at drive time, popped on csr_we_o.
module tb_beta_trap_ctrl;
  import beta_trap_pkg::*;

  localparam int NL = 4;
  localparam int XL = 32;
  localparam int NI = 16 + NL;
`ifdef BETA_TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  beta_trap_ctrl_if #(.NUM_LOCAL_IRQ(NL), .XLEN(XL)) bus ();
  beta_trap_ctrl #(.NUM_LOCAL_IRQ(NL), .XLEN(XL)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  ttype;
    logic [31:0] cause, epc, tval, tpc;
  } take_t;

  take_t exp_q[$];
  take_t obs, exp_t;
  int    lat;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_valid_i = 1'b0; bus.pc_i = '0; bus.instr_trap_i = 2'b00; bus.lsu_trap_i = 2'b00;
    bus.ecall_i = 1'b0; bus.instr_word_i = '0; bus.badaddr_i = '0; bus.mret_i = 1'b0;
    bus.irq_msw_i = 1'b0; bus.irq_mtim_i = 1'b0; bus.irq_mext_i = 1'b0;
    bus.irq_local_i = '0; bus.flush_ack_i = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] t, input logic [31:0] c, e, v, p);
    exp_q.push_back(take_t'({t, c, e, v, p}));
  endtask

  // Waits a bounded number of cycles for the capture strobe; lat=0 means it never came.
  task automatic wait_take(output take_t o, output int l);
    l = 0;
    o = '0;
    do begin tick(); l++; end while (!bus.csr_we_o && l < 4);
    if (bus.csr_we_o) o = {bus.trap_type_o, bus.mcause_o, bus.mepc_o, bus.mtval_o, bus.trap_pc_o};
    else l = 0;
  endtask

  task automatic ack();
    bus.flush_ack_i = 1'b1;
    tick();
    bus.flush_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.mstatus_mie_i = 1'b0; bus.mie_i = '0; bus.mtvec_i = 32'h1000;
    repeat (3) tick();
    n_vec++;
    if ({bus.trap_req_o, bus.trap_type_o, bus.trap_pc_o, bus.mcause_o, bus.mepc_o, bus.mtval_o,
         bus.csr_we_o, bus.mret_o, bus.mip_o} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got req=%b mcause=%h mip=%h, all zero expected",
                        bus.trap_req_o, bus.mcause_o, bus.mip_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    bus.instr_valid_i = 1'b1; bus.instr_trap_i = ITRAP_ILLEGAL; bus.pc_i = 32'h100;
    bus.instr_word_i = 32'hFFFF_FFFF;
    push_exp(TRAP_EXC, 32'd2, 32'h100, 32'hFFFF_FFFF, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL illegal_take: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    repeat (2) tick();
    n_vec++;
    if (bus.trap_req_o !== 1'b1 || bus.trap_type_o !== TRAP_EXC || bus.csr_we_o !== 1'b0) begin
      n_err++; $display("FAIL illegal_hold: req=%b type=%b we=%b exp 1/10/0",
                        bus.trap_req_o, bus.trap_type_o, bus.csr_we_o);
    end
    ack();
    n_vec++;
    if (bus.trap_req_o !== 1'b0 || bus.trap_type_o !== TRAP_NONE) begin
      n_err++; $display("FAIL illegal_release: req=%b type=%b exp 0/00", bus.trap_req_o, bus.trap_type_o);
    end
  endtask

  task automatic test_exc_vs_irq();
    bus.mstatus_mie_i = 1'b1; bus.mie_i = '1;
    bus.instr_valid_i = 1'b1; bus.irq_mext_i = 1'b1; bus.lsu_trap_i = LTRAP_LOAD;
    bus.badaddr_i = 32'h203; bus.pc_i = 32'h200;
    push_exp(TRAP_EXC, 32'd4, 32'h200, 32'h203, 32'h1000);
    push_exp(TRAP_IRQ, 32'h8000_000B, 32'h204, 32'h0, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL exc_beats_irq: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    bus.lsu_trap_i = LTRAP_NONE; bus.badaddr_i = '0; bus.pc_i = 32'h204;
    ack();
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL irq_after_ack: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    ack();
  endtask

  task automatic test_exc_prio();
    // {instr_trap, lsu_trap, ecall, cause, tval_is_badaddr, tval_is_word}
    logic [1:0] it[5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] lt[5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    logic       ec[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] cs[5] = '{5'd0, 5'd2, 5'd11, 5'd4, 5'd6};
    logic [31:0] tv[5] = '{32'hA0, 32'hC0FFEE00, 32'h0, 32'hA3, 32'hA4};
    for (int k = 0; k < 5; k++) begin
      bus.irq_mtim_i = 1'b1;
      bus.instr_valid_i = 1'b1; bus.pc_i = 32'h300 + 32'(k * 4);
      bus.instr_trap_i = it[k]; bus.lsu_trap_i = lt[k]; bus.ecall_i = ec[k];
      bus.badaddr_i = tv[k]; bus.instr_word_i = (k == 1) ? 32'hC0FFEE00 : 32'h0;
      push_exp(TRAP_EXC, 32'(cs[k]), 32'h300 + 32'(k * 4), tv[k], 32'h1000);
      wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
      if (lat != 1 || obs !== exp_t) begin
        n_err++; $display("FAIL exc_prio[%0d]: lat=%0d got %h exp %h", k, lat, obs, exp_t);
      end
      idle_inputs();
      ack();
    end
  endtask

  task automatic test_irq_prio();
    logic [2:0] lv[3] = '{3'b111, 3'b011, 3'b010};  // {mext, mtim, msw}
    logic [4:0] cs[3] = '{5'd11, 5'd3, 5'd7};
    for (int k = 0; k < 3; k++) begin
      {bus.irq_mext_i, bus.irq_mtim_i, bus.irq_msw_i} = lv[k];
      bus.instr_valid_i = 1'b1; bus.pc_i = 32'h380 + 32'(k * 4);
      push_exp(TRAP_IRQ, 32'h8000_0000 | 32'(cs[k]), 32'h380 + 32'(k * 4), 32'h0, 32'h1000);
      wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
      if (lat != 1 || obs !== exp_t) begin
        n_err++; $display("FAIL irq_prio[%0d]: lat=%0d got %h exp %h", k, lat, obs, exp_t);
      end
      idle_inputs();
      ack();
    end
    bus.mie_i[7] = 1'b0;
    bus.irq_mtim_i = 1'b1; bus.instr_valid_i = 1'b1; bus.pc_i = 32'h390;
    repeat (2) tick();
    n_vec++;
    if (bus.trap_req_o !== 1'b0 || bus.mip_o[7] !== 1'b1) begin
      n_err++; $display("FAIL irq_masked: req=%b mip7=%b exp 0/1", bus.trap_req_o, bus.mip_o[7]);
    end
    bus.mie_i[7] = 1'b1;
    push_exp(TRAP_IRQ, 32'h8000_0007, 32'h390, 32'h0, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL irq_unmasked: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    ack();
  endtask

  task automatic test_local();
    bus.mstatus_mie_i = 1'b0;
    bus.irq_local_i[2] = 1'b1; tick();
    bus.irq_local_i[2] = 1'b0; repeat (3) tick();
    n_vec++;
    if (bus.mip_o[18] !== 1'b1 || bus.trap_req_o !== 1'b0) begin
      n_err++; $display("FAIL local_latch: mip18=%b req=%b exp 1/0", bus.mip_o[18], bus.trap_req_o);
    end
    bus.mstatus_mie_i = 1'b1; bus.instr_valid_i = 1'b1; bus.pc_i = 32'h800;
    push_exp(TRAP_IRQ, 32'h8000_0012, 32'h800, 32'h0, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t || bus.mip_o[18] !== 1'b0) begin
      n_err++; $display("FAIL local_take: lat=%0d mip18=%b got %h exp %h", lat, bus.mip_o[18], obs, exp_t);
    end
    idle_inputs();
    ack();
    // New edge on the same line in the take cycle keeps the bit pending.
    bus.mstatus_mie_i = 1'b0;
    bus.irq_local_i[2] = 1'b1; tick();
    bus.irq_local_i[2] = 1'b0; tick();
    bus.mstatus_mie_i = 1'b1; bus.instr_valid_i = 1'b1; bus.pc_i = 32'h804; bus.irq_local_i[2] = 1'b1;
    push_exp(TRAP_IRQ, 32'h8000_0012, 32'h804, 32'h0, 32'h1000);
    push_exp(TRAP_IRQ, 32'h8000_0012, 32'h808, 32'h0, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t || bus.mip_o[18] !== 1'b1) begin
      n_err++; $display("FAIL local_set_wins: lat=%0d mip18=%b got %h exp %h", lat, bus.mip_o[18], obs, exp_t);
    end
    idle_inputs();
    ack();
    bus.instr_valid_i = 1'b1; bus.pc_i = 32'h808;
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t || bus.mip_o[18] !== 1'b0) begin
      n_err++; $display("FAIL local_retake: lat=%0d mip18=%b got %h exp %h", lat, bus.mip_o[18], obs, exp_t);
    end
    idle_inputs();
    ack();
    // Two local lines pending: highest index first.
    bus.mstatus_mie_i = 1'b0;
    bus.irq_local_i = 4'b1001; tick();
    bus.irq_local_i = 4'b0000; tick();
    bus.mstatus_mie_i = 1'b1;
    push_exp(TRAP_IRQ, 32'h8000_0013, 32'h810, 32'h0, 32'h1000);
    push_exp(TRAP_IRQ, 32'h8000_0010, 32'h814, 32'h0, 32'h1000);
    for (int k = 0; k < 2; k++) begin
      bus.instr_valid_i = 1'b1; bus.pc_i = 32'h810 + 32'(k * 4);
      wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
      if (lat != 1 || obs !== exp_t) begin
        n_err++; $display("FAIL local_prio[%0d]: lat=%0d got %h exp %h", k, lat, obs, exp_t);
      end
      idle_inputs();
      ack();
    end
  endtask

  task automatic test_vectored();
    bus.mtvec_i = 32'h1001;
    bus.irq_mtim_i = 1'b1; bus.instr_valid_i = 1'b1; bus.pc_i = 32'h500;
    push_exp(TRAP_IRQ, 32'h8000_0007, 32'h500, 32'h0, VEC ? 32'h101C : 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL vectored_irq: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    ack();
    bus.instr_valid_i = 1'b1; bus.pc_i = 32'h504; bus.instr_trap_i = ITRAP_ILLEGAL;
    bus.instr_word_i = 32'hDEAD_BEEF;
    push_exp(TRAP_EXC, 32'd2, 32'h504, 32'hDEAD_BEEF, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL vectored_exc_base: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    ack();
    bus.mtvec_i = 32'h1000;
  endtask

  task automatic test_mret();
    bus.instr_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.pc_i = 32'h400;
    push_exp(TRAP_EXC, 32'd11, 32'h400, 32'h0, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL ecall_take: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    ack();
    bus.mret_i = 1'b1; tick();
    bus.mret_i = 1'b0;
    n_vec++;
    if (bus.mret_o !== 1'b1 || bus.csr_we_o !== 1'b0 || bus.mepc_o !== 32'h400) begin
      n_err++; $display("FAIL mret_pulse: mret=%b we=%b mepc=%h exp 1/0/400",
                        bus.mret_o, bus.csr_we_o, bus.mepc_o);
    end
    tick();
    n_vec++;
    if (bus.mret_o !== 1'b0) begin
      n_err++; $display("FAIL mret_one_cycle: mret=%b exp 0", bus.mret_o);
    end
    bus.mret_i = 1'b1; bus.instr_valid_i = 1'b1; bus.instr_trap_i = ITRAP_ILLEGAL;
    bus.pc_i = 32'h404; bus.instr_word_i = 32'h1234_5678;
    push_exp(TRAP_EXC, 32'd2, 32'h404, 32'h1234_5678, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t || bus.mret_o !== 1'b0) begin
      n_err++; $display("FAIL mret_loses: lat=%0d mret=%b got %h exp %h", lat, bus.mret_o, obs, exp_t);
    end
    idle_inputs();
    ack();
  endtask

  task automatic test_back_to_back();
    bus.instr_valid_i = 1'b1; bus.instr_trap_i = ITRAP_ILLEGAL; bus.pc_i = 32'h600;
    bus.instr_word_i = 32'h0000_0013;
    push_exp(TRAP_EXC, 32'd2, 32'h600, 32'h13, 32'h1000);
    push_exp(TRAP_EXC, 32'd11, 32'h604, 32'h0, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL b2b_first: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    // Ack in the first TRAP cycle while a new source is already present.
    bus.instr_trap_i = ITRAP_NONE; bus.ecall_i = 1'b1; bus.pc_i = 32'h604;
    bus.flush_ack_i = 1'b1; tick(); bus.flush_ack_i = 1'b0;
    n_vec++;
    if (bus.csr_we_o !== 1'b0 || bus.trap_req_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_gap: we=%b req=%b exp 0/0", bus.csr_we_o, bus.trap_req_o);
    end
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL b2b_second: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    ack();
  endtask

  task automatic test_reset_mid_trap();
    bus.instr_valid_i = 1'b1; bus.instr_trap_i = ITRAP_ILLEGAL; bus.pc_i = 32'h700;
    bus.instr_word_i = 32'hFFFF_0000;
    push_exp(TRAP_EXC, 32'd2, 32'h700, 32'hFFFF_0000, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL pre_reset_take: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    bus.mstatus_mie_i = 1'b0;
    bus.irq_local_i[1] = 1'b1; tick();
    n_vec++;
    if (bus.mip_o[17] !== 1'b1 || bus.trap_req_o !== 1'b1) begin
      n_err++; $display("FAIL latch_in_trap: mip17=%b req=%b exp 1/1", bus.mip_o[17], bus.trap_req_o);
    end
    #2 rst_i = 1'b1;
    #1;
    n_vec++;
    if (bus.trap_req_o !== 1'b0 || bus.mcause_o !== '0 || bus.mepc_o !== '0 ||
        bus.mip_o[NI-1:16] !== '0) begin
      n_err++; $display("FAIL async_reset: req=%b mcause=%h mepc=%h mip_local=%h exp all 0",
                        bus.trap_req_o, bus.mcause_o, bus.mepc_o, bus.mip_o[NI-1:16]);
    end
    bus.irq_local_i = '0;
    tick();
    rst_i = 1'b0;
    bus.instr_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.pc_i = 32'h710;
    push_exp(TRAP_EXC, 32'd11, 32'h710, 32'h0, 32'h1000);
    wait_take(obs, lat); exp_t = exp_q.pop_front(); n_vec++;
    if (lat != 1 || obs !== exp_t) begin
      n_err++; $display("FAIL post_reset_take: lat=%0d got %h exp %h", lat, obs, exp_t);
    end
    idle_inputs();
    ack();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_exc_vs_irq();
    test_exc_prio();
    test_irq_prio();
    test_local();
    test_vectored();
    test_mret();
    test_back_to_back();
    test_reset_mid_trap();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, 0 expected", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
